// File: rtl/alu.sv
// 32-bit ALU with a combinational result and zero flag, plus a registered copy of both.
// Define ALU_SHIFT_EN to enable SLL/SRL on codes 110/111; otherwise those codes give zero.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  operation,
  output logic [31:0] res,
  output logic        flag,
  output logic [31:0] res_q,
  output logic        flag_q
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } aluOp_e;

  aluOp_e op;
  logic   sltBit;

  assign op     = aluOp_e'(operation);
  assign sltBit = $signed(srcA) < $signed(srcB);

  // Codes without a compiled-in function fall through to the zero default.
  always_comb begin
    res = 32'h0;
    case (op)
      OP_ADD:  res = srcA + srcB;
      OP_SUB:  res = srcA - srcB;
      OP_AND:  res = srcA & srcB;
      OP_OR:   res = srcA | srcB;
      OP_XOR:  res = srcA ^ srcB;
      OP_SLT:  res = {31'h0, sltBit};
`ifdef ALU_SHIFT_EN
      OP_SLL:  res = srcA << srcB[4:0];
      OP_SRL:  res = srcA >> srcB[4:0];
`endif
      default: res = 32'h0;
    endcase
  end

  assign flag = (res == 32'h0);

  // Reset clears the flag copy to 0 even though a zero result would otherwise set it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= 32'h0;
      flag_q <= 1'b0;
    end else begin
      res_q  <= res;
      flag_q <= flag;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and randomized
// operations compared against an arithmetic reference model (honours ALU_SHIFT_EN).
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [2:0]  operation;
  logic [31:0] res;
  logic        flag;
  logic [31:0] res_q;
  logic        flag_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk(clk),
    .rst(rst),
    .srcA(srcA),
    .srcB(srcB),
    .operation(operation),
    .res(res),
    .flag(flag),
    .res_q(res_q),
    .flag_q(flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain arithmetic on wide integers, not bit operators on the adder.
  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    longint unsigned wa = {32'h0, a};
    longint unsigned wb = {32'h0, b};
    longint unsigned m  = 64'h1_0000_0000;
    longint unsigned sh = 64'd1 << (wb % 32);
    case (op)
      3'd0: return 32'((wa + wb) % m);
      3'd1: return 32'((m + wa - wb) % m);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'd6: return 32'((wa * sh) % m);
      3'd7: return 32'(wa / sh);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    srcA      = a;
    srcB      = b;
    operation = op;
    #1;
  endtask

  logic [31:0] expRes;
  logic [31:0] prevRegRes;
  logic        prevRegFlag;
  logic        rstNow;

  initial begin
    rst = 1'b1;
    srcA = 32'h0;
    srcB = 32'h0;
    operation = 3'd0;

    // Reset state: registered copy cleared, combinational path unaffected.
    @(posedge clk);
    #1;
    checkOutput("reset res_q", res_q, 32'h0);
    checkOutput("reset flag_q", {31'h0, flag_q}, 32'h0);
    checkOutput("reset comb flag", {31'h0, flag}, 32'h1);

    vecs.push_back('{"eq add",  32'd1025, 32'd1025, 3'd0, 32'h802});
    vecs.push_back('{"eq sub",  32'd1025, 32'd1025, 3'd1, 32'h0});
    vecs.push_back('{"eq and",  32'd1025, 32'd1025, 3'd2, 32'h401});
    vecs.push_back('{"eq or",   32'd1025, 32'd1025, 3'd3, 32'h401});
    vecs.push_back('{"eq xor",  32'd1025, 32'd1025, 3'd4, 32'h0});
    vecs.push_back('{"eq slt",  32'd1025, 32'd1025, 3'd5, 32'h0});
    vecs.push_back('{"gt add",  32'd1025, 32'd1000, 3'd0, 32'd2025});
    vecs.push_back('{"gt sub",  32'd1025, 32'd1000, 3'd1, 32'd25});
    vecs.push_back('{"gt and",  32'd1025, 32'd1000, 3'd2, 32'h0});
    vecs.push_back('{"gt or",   32'd1025, 32'd1000, 3'd3, 32'h7E9});
    vecs.push_back('{"gt xor",  32'd1025, 32'd1000, 3'd4, 32'h7E9});
    vecs.push_back('{"gt slt",  32'd1025, 32'd1000, 3'd5, 32'h0});
    vecs.push_back('{"lt sub",  32'd513,  32'd1000, 3'd1, 32'hFFFFFE19});
    vecs.push_back('{"lt and",  32'd513,  32'd1000, 3'd2, 32'h200});
    vecs.push_back('{"lt or",   32'd513,  32'd1000, 3'd3, 32'h3E9});
    vecs.push_back('{"lt xor",  32'd513,  32'd1000, 3'd4, 32'h1E9});
    vecs.push_back('{"lt slt",  32'd513,  32'd1000, 3'd5, 32'h1});
    vecs.push_back('{"neg slt0", 32'h8000_0000, 32'h0, 3'd5, 32'h1});
    vecs.push_back('{"neg slt1", 32'h8000_0000, 32'h1, 3'd5, 32'h1});
    vecs.push_back('{"wrap add", 32'hFFFF_FFFF, 32'h1, 3'd0, 32'h0});
`ifdef ALU_SHIFT_EN
    vecs.push_back('{"sll",      32'h1,  32'h25, 3'd6, 32'h20});
    vecs.push_back('{"srl",      32'h80, 32'h25, 3'd7, 32'h04});
`else
    vecs.push_back('{"op110 off", 32'h1, 32'h25, 3'd6, 32'h0});
    vecs.push_back('{"op111 off", 32'h80, 32'h25, 3'd7, 32'h0});
`endif

    rst = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
      checkOutput({vecs[i].tag, " res"}, res, vecs[i].exp);
      checkOutput({vecs[i].tag, " flag"}, {31'h0, flag}, {31'h0, vecs[i].exp == 32'h0});
    end

    // Registered path, then reset overriding capture while res holds.
    applyStimulus(32'd1, 32'd2, 3'd0);
    @(posedge clk);
    #1;
    checkOutput("reg add res_q", res_q, 32'd3);
    checkOutput("reg add flag_q", {31'h0, flag_q}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst res_q", res_q, 32'h0);
    checkOutput("rst flag_q", {31'h0, flag_q}, 32'h0);
    checkOutput("rst res held", res, 32'd3);
    checkOutput("rst flag held", {31'h0, flag}, 32'h0);
    rst = 1'b0;

    prevRegRes  = 32'h0;
    prevRegFlag = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      rstNow = ($urandom_range(0, 15) == 0);
      applyStimulus(a, b, op);
      rst = rstNow;
      expRes = refModel(a, b, op);
      checkOutput("rand res", res, expRes);
      checkOutput("rand flag", {31'h0, flag}, {31'h0, expRes == 32'h0});
      checkOutput("rand res_q hold", res_q, prevRegRes);
      checkOutput("rand flag_q hold", {31'h0, flag_q}, {31'h0, prevRegFlag});
      @(posedge clk);
      #1;
      prevRegRes  = rstNow ? 32'h0 : expRes;
      prevRegFlag = rstNow ? 1'b0 : (expRes == 32'h0);
      checkOutput("rand res_q", res_q, prevRegRes);
      checkOutput("rand flag_q", {31'h0, flag_q}, {31'h0, prevRegFlag});
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for the registered result copy.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 srcA  input  32  operand A.
REQ-005 srcB  input  32  operand B.
REQ-006 operation  input  3  operation select.
REQ-007 res  output  32  combinational result.
REQ-008 flag  output  1  combinational zero flag, 1 when res == 0.
REQ-009 res_q  output  32  res registered on each rising clk edge.
REQ-010 flag_q  output  1  flag registered on each rising clk edge.

Function
REQ-011 The res and flag outputs SHALL be purely combinational from srcA, srcB and operation, with zero-cycle latency and no handshake.
REQ-012 000 ADD: res = srcA + srcB, modulo 2^32, with carry discarded.
REQ-013 001 SUB: res = srcA - srcB, modulo 2^32, with borrow discarded.
REQ-014 010 AND: res = srcA & srcB, bitwise.
REQ-015 011 OR: res = srcA | srcB, bitwise.
REQ-016 100 XOR: res = srcA ^ srcB, bitwise.
REQ-017 101 SLT: res = 32'd1 if $signed(srcA) < $signed(srcB), else 32'd0.
REQ-018 Codes 110 and 111 SHALL behave as defined under Configuration.
REQ-019 flag SHALL equal (res == 32'h0) for every operation, including undefined codes.
REQ-020 Equal operands with SUB SHALL give res = 0 and flag = 1; this is the branch-equal condition.
REQ-021 SLT SHALL compare signed values: srcA = 32'h8000_0000, srcB = 0 gives res = 1.
REQ-022 Overflow SHALL NOT be flagged; ADD/SUB wrap silently.
REQ-023 res_q/flag_q SHALL capture res/flag on every rising clk edge when rst = 0, giving 1-cycle latency.
REQ-024 An operand or operation change between edges SHALL affect res/flag immediately and res_q/flag_q only at the next edge.

Reset
REQ-025 When rst = 1 at a rising edge, res_q SHALL become 32'h0 and flag_q SHALL become 1'b0.
REQ-026 When rst is asserted mid-operation, it SHALL override capture at that edge.
REQ-027 res and flag SHALL be unaffected by rst.

Configuration
REQ-028 The macro ALU_SHIFT_EN SHALL compile the shift operations in or out.
- Defined: 110 SLL, res = srcA << srcB[4:0]; 111 SRL, res = srcA >> srcB[4:0] (logical, zero-fill); srcB[31:5] ignored.
- Undefined: codes 110 and 111 give res = 32'h0 and flag = 1, and no shifter logic is synthesized.

Verification
REQ-029 srcA = srcB = 1025: ADD -> 0x802, flag 0; SUB -> 0, flag 1; AND -> 0x401; OR -> 0x401; XOR -> 0, flag 1; SLT -> 0, flag 1.
REQ-030 srcA = 1025, srcB = 1000: ADD -> 2025; SUB -> 25; AND -> 0; OR -> 0x7E9; XOR -> 0x7E9; SLT -> 0, flag 1.
REQ-031 srcA = 513, srcB = 1000: SUB -> 0xFFFFFE19, flag 0; AND -> 0x200; OR -> 0x3E9; XOR -> 0x1E9; SLT -> 1.
REQ-032 Signed boundary: srcA = 0x8000_0000, srcB = 1: SLT -> 1. Wrap boundary: srcA = 0xFFFF_FFFF, srcB = 1: ADD -> 0, flag 1.
REQ-033 Registered path: apply ADD 1 + 2, then clock -> res_q = 3, flag_q = 0. Then apply rst = 1 and clock -> res_q = 0, flag_q = 0, while res stays 3.
REQ-034 Configuration check: with ALU_SHIFT_EN, srcA = 1, srcB = 0x25, op 110 -> 0x20; op 111 with srcA = 0x80 -> 0x04. Without it, op 110 -> 0, flag 1.
